axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_pkg.sv | 24 ++
 rtl/axi_burst_master_if.sv | 47 ++++
 rtl/axi_cmd_check.sv | 34 +++
 rtl/axi_burst_master.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared constants and types for the AXI burst master.
//   - burst type encodings (FIXED/INCR/WRAP)
//   - response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   - write/read FSM state encodings
//   - resp_max(): worst-of-two response helper used by the read path
package axi_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rstate_t;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 AW/W/B/AR/R channel bundle.
//   master modport: drives AW/W/AR payload+valid, bready, rready.
//   slave  modport: drives awready, wready, B channel, arready, R channel.
// Parameters: DATA_W (data width), ADDR_W (address width).
interface axi_burst_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic       bvalid, bready;
  logic [1:0] bresp;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast,            input wready,
    input  bvalid, bresp,                          output bready,
    output arvalid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast,            output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast,            output wready,
    output bvalid, bresp,                          input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast,            input  rready
  );
endinterface

// File: rtl/axi_cmd_check.sv
// axi_cmd_check: combinational legality check of a burst command.
// Ports:
//   cmd_addr/cmd_len/cmd_size/cmd_burst  in   command payload
//   illegal                              out  1 = command must be rejected
// A command is illegal when the burst type is reserved, the beat size is
// wider than the data bus, or a WRAP burst has a non power-of-two beat count
// (2/4/8/16) or a start address not aligned to the beat size.
module axi_cmd_check
  import axi_burst_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              illegal
);
  localparam int SZ_MAX = $clog2(DATA_W/8);

  logic [ADDR_W-1:0] mask;
  logic              wrap, len_bad, unaligned;

  always_comb begin
    mask      = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
    wrap      = (cmd_burst == BURST_WRAP);
    len_bad   = !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15});
    unaligned = |(cmd_addr & mask);
    illegal   = (cmd_burst == 2'd3) ||
                (cmd_size > 3'(SZ_MAX)) ||
                (wrap && (len_bad || unaligned));
  end
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: independent AXI4 write and read burst engines sharing
// one command payload.
// Ports:
//   aclk, resetn                 clock, async active-low reset
//   wr_start/rd_start            command pulses (both may fire together)
//   cmd_addr/len/size/burst      payload, sampled on an accepted start
//   wr_busy/rd_busy              channel active
//   wr_done/rd_done, *_resp      one-cycle done pulse, status held
//   wd_valid/wd_ready/wd_data    user write stream -> W channel
//   rd_valid/rd_ready/rd_data/rd_last  R channel -> user read stream
//   axi                          AXI master modport
// Optional: define AXI_BURST_MASTER_TIMEOUT_EN to abort W_RESP / R_DATA after
// TMO_CYC cycles without a handshake (done with DECERR).
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 1024
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic [1:0]        wr_resp,
  output logic [1:0]        rd_resp,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  axi_burst_master_if.master axi
);

  wstate_t    wstate;
  rstate_t    rstate;
  logic [7:0] wbeat, rbeat;
  logic [1:0] rmax;
  logic       rerr;     // rlast missing on the final beat
  logic       wr_bad, rd_bad;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] wtmo, rtmo;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  axi_cmd_check #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wchk (
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .illegal(wr_bad));

  axi_cmd_check #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rchk (
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .illegal(rd_bad));

  // Data streams are pass-through during the data phase; gated to zero
  // otherwise so nothing leaks onto the bus outside a burst.
  logic wact, ract;
  assign wact       = (wstate == W_DATA);
  assign ract       = (rstate == R_DATA);
  assign axi.wvalid = wact & wd_valid;
  assign axi.wdata  = wact ? wd_data : '0;
  assign axi.wstrb  = {(DATA_W/8){wact}};
  assign axi.wlast  = wact && (wbeat == axi.awlen);
  assign wd_ready   = wact & axi.wready;

  assign axi.rready = ract & rd_ready;
  assign rd_valid   = ract & axi.rvalid;
  assign rd_data    = ract ? axi.rdata : '0;
  assign rd_last    = ract & axi.rlast;

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wstate      <= W_IDLE;
      wbeat       <= '0;
      wr_busy     <= 1'b0;
      wr_done     <= 1'b0;
      wr_resp     <= '0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awlen   <= '0;
      axi.awsize  <= '0;
      axi.awburst <= '0;
      axi.bready  <= 1'b0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
      wtmo        <= '0;
`endif
    end else begin
      wr_done <= 1'b0;
      case (wstate)
        W_IDLE: if (wr_start) begin
          if (wr_bad) begin
            wr_done <= 1'b1;
            wr_resp <= RESP_SLVERR;
          end else begin
            axi.awvalid <= 1'b1;
            axi.awaddr  <= cmd_addr;
            axi.awlen   <= cmd_len;
            axi.awsize  <= cmd_size;
            axi.awburst <= cmd_burst;
            wbeat       <= '0;
            wr_busy     <= 1'b1;
            wstate      <= W_ADDR;
          end
        end
        W_ADDR: if (axi.awready) begin
          axi.awvalid <= 1'b0;
          wstate      <= W_DATA;
        end
        W_DATA: if (axi.wvalid && axi.wready) begin
          wbeat <= wbeat + 8'd1;
          if (axi.wlast) begin
            axi.bready <= 1'b1;
            wstate     <= W_RESP;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            wtmo       <= '0;
`endif
          end
        end
        W_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            wr_busy    <= 1'b0;
            wr_done    <= 1'b1;
            wr_resp    <= axi.bresp;
            wstate     <= W_IDLE;
          end
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
          else if (wtmo == TW'(TMO_CYC - 1)) begin
            axi.bready <= 1'b0;
            wr_busy    <= 1'b0;
            wr_done    <= 1'b1;
            wr_resp    <= RESP_DECERR;
            wstate     <= W_IDLE;
          end else begin
            wtmo <= wtmo + 1'b1;
          end
`endif
        end
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      rstate      <= R_IDLE;
      rbeat       <= '0;
      rmax        <= '0;
      rerr        <= 1'b0;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      rd_resp     <= '0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arsize  <= '0;
      axi.arburst <= '0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
      rtmo        <= '0;
`endif
    end else begin
      rd_done <= 1'b0;
      case (rstate)
        R_IDLE: if (rd_start) begin
          if (rd_bad) begin
            rd_done <= 1'b1;
            rd_resp <= RESP_SLVERR;
          end else begin
            axi.arvalid <= 1'b1;
            axi.araddr  <= cmd_addr;
            axi.arlen   <= cmd_len;
            axi.arsize  <= cmd_size;
            axi.arburst <= cmd_burst;
            rbeat       <= '0;
            rmax        <= RESP_OKAY;
            rerr        <= 1'b0;
            rd_busy     <= 1'b1;
            rstate      <= R_ADDR;
          end
        end
        R_ADDR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          rstate      <= R_DATA;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
          rtmo        <= '0;
`endif
        end
        R_DATA: begin
          if (axi.rvalid && axi.rready) begin
            rbeat <= rbeat + 8'd1;
            rmax  <= resp_max(rmax, axi.rresp);
            // slave ran past the last expected beat without rlast
            if (!axi.rlast && rbeat == axi.arlen) rerr <= 1'b1;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            rtmo  <= '0;
`endif
            if (axi.rlast) begin
              rd_busy <= 1'b0;
              rd_done <= 1'b1;
              rd_resp <= (rerr || rbeat != axi.arlen) ? RESP_SLVERR
                                                      : resp_max(rmax, axi.rresp);
              rstate  <= R_IDLE;
            end
          end
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
          else if (rtmo == TW'(TMO_CYC - 1)) begin
            rd_busy <= 1'b0;
            rd_done <= 1'b1;
            rd_resp <= RESP_DECERR;
            rstate  <= R_IDLE;
          end else begin
            rtmo <= rtmo + 1'b1;
          end
`endif
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (DATA_W=32, ADDR_W=32, TMO_CYC=16).
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        wr_start, rd_start;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wr_busy, rd_busy, wr_done, rd_done;
  logic [1:0]  wr_resp, rd_resp;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;

  axi_burst_master_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axi_burst_master #(.DATA_W(32), .ADDR_W(32), .TMO_CYC(16)) dut (
    .aclk(aclk), .resetn(resetn), .wr_start(wr_start), .rd_start(rd_start),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done),
    .wr_resp(wr_resp), .rd_resp(rd_resp),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .axi(bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then settle 1ns past the edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] a, input logic [7:0] l,
                     input logic [2:0] s, input logic [1:0] b);
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
  endtask

  initial begin
    resetn = 1'b0; wr_start = 0; rd_start = 0; cmd(0, 0, 0, 0);
    wd_valid = 0; wd_data = 0; rd_ready = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    #2;
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_busy",    {wr_busy, rd_busy}, 0);
    chk("rst_done",    {wr_done, rd_done}, 0);
    chk("rst_resp",    {wr_resp, rd_resp}, 0);
    tick(); tick();
    resetn = 1'b1;

    // ---- basic INCR write, len 3, all ready ----
    cmd(32'h100, 8'd3, 3'd2, BURST_INCR);
    wr_start = 1; bus.awready = 1; bus.wready = 1; wd_valid = 1;
    tick();
    wr_start = 0; #1;
    chk("w1_awvalid", bus.awvalid, 1);
    chk("w1_awaddr",  bus.awaddr, 32'h100);
    chk("w1_awlen",   bus.awlen, 3);
    chk("w1_awsize",  bus.awsize, 2);
    chk("w1_awburst", bus.awburst, 1);
    chk("w1_busy",    wr_busy, 1);
    chk("w1_nowbeat", bus.wvalid, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      wd_data = 32'(b + 1); #1;
      chk("w1_wvalid", bus.wvalid, 1);
      chk("w1_wdata",  bus.wdata, 32'(b + 1));
      chk("w1_wlast",  bus.wlast, (b == 3));
      chk("w1_wstrb",  bus.wstrb, 4'hf);
      chk("w1_wdready", wd_ready, 1);
      tick();
    end
    wd_valid = 0; #1;
    chk("w1_bready", bus.bready, 1);
    chk("w1_wvalid0", bus.wvalid, 0);
    chk("w1_nodone", wr_done, 0);
    bus.bvalid = 1; bus.bresp = RESP_OKAY;
    tick();
    bus.bvalid = 0; #1;
    chk("w1_done", wr_done, 1);
    chk("w1_resp", wr_resp, 0);
    chk("w1_idle", wr_busy, 0);
    tick();
    chk("w1_donepulse", wr_done, 0);

    // ---- awready delayed 5 cycles ----
    bus.awready = 0;
    cmd(32'h200, 8'd1, 3'd2, BURST_INCR);
    wr_start = 1; wd_valid = 1; wd_data = 32'hA0;
    tick();
    wr_start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("w2_awvalid", bus.awvalid, 1);
      chk("w2_awaddr",  bus.awaddr, 32'h200);
      chk("w2_nowbeat", bus.wvalid, 0);
      if (i == 4) bus.awready = 1;
      tick();
    end
    bus.awready = 0; #1;
    chk("w2_awdrop", bus.awvalid, 0);
    chk("w2_b0", {bus.wvalid, bus.wlast, bus.wdata}, {2'b10, 32'hA0});
    tick();
    wd_data = 32'hA1; #1;
    chk("w2_b1", {bus.wvalid, bus.wlast, bus.wdata}, {2'b11, 32'hA1});
    tick();
    wd_valid = 0; bus.bvalid = 1;
    tick();
    bus.bvalid = 0; #1;
    chk("w2_done", {wr_done, wr_resp}, 3'b100);

    // ---- read len 7, SLVERR on 3rd beat ----
    cmd(32'h400, 8'd7, 3'd2, BURST_INCR);
    rd_start = 1; bus.arready = 1; rd_ready = 1;
    tick();
    rd_start = 0; #1;
    chk("r1_arvalid", bus.arvalid, 1);
    chk("r1_araddr",  bus.araddr, 32'h400);
    chk("r1_arlen",   bus.arlen, 7);
    tick();
    bus.arready = 0;
    for (int b = 0; b < 8; b++) begin
      bus.rvalid = 1; bus.rdata = 32'h1000 + 32'(b);
      bus.rresp = (b == 2) ? RESP_SLVERR : RESP_OKAY; bus.rlast = (b == 7);
      #1;
      chk("r1_rdvalid", rd_valid, 1);
      chk("r1_rddata",  rd_data, 32'h1000 + 32'(b));
      chk("r1_rdlast",  rd_last, (b == 7));
      chk("r1_rready",  bus.rready, 1);
      chk("r1_nodone",  rd_done, 0);
      tick();
    end
    bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; #1;
    chk("r1_done", rd_done, 1);
    chk("r1_resp", rd_resp, 2);
    chk("r1_idle", rd_busy, 0);

    // ---- concurrent write + read ----
    cmd(32'h800, 8'd1, 3'd2, BURST_INCR);
    wr_start = 1; rd_start = 1; bus.awready = 1; bus.arready = 1;
    tick();
    wr_start = 0; rd_start = 0; #1;
    chk("c_busy",  {wr_busy, rd_busy}, 2'b11);
    chk("c_valid", {bus.awvalid, bus.arvalid}, 2'b11);
    chk("c_addr",  {bus.awaddr, bus.araddr}, {32'h800, 32'h800});
    tick();
    wd_valid = 1; wd_data = 32'h55; bus.rvalid = 1; bus.rdata = 32'h66; #1;
    chk("c_beat0", {bus.wvalid, rd_valid, bus.wlast, rd_last}, 4'b1100);
    tick();
    bus.rlast = 1; #1;
    chk("c_beat1", {bus.wvalid, rd_valid, bus.wlast, rd_last}, 4'b1111);
    tick();
    wd_valid = 0; bus.rvalid = 0; bus.rlast = 0; bus.bvalid = 1; #1;
    chk("c_rdone", {rd_done, rd_resp}, 3'b100);
    tick();
    bus.bvalid = 0; #1;
    chk("c_wdone", {wr_done, wr_resp}, 3'b100);

    // ---- illegal commands; back-to-back accepted while done is high ----
    bus.awready = 0; bus.arready = 0;
    cmd(32'h100, 8'd3, 3'd2, 2'd3);
    wr_start = 1; rd_start = 1;
    tick();
    chk("i1_done", {wr_done, rd_done}, 2'b11);
    chk("i1_resp", {wr_resp, rd_resp}, 4'b1010);
    chk("i1_noaxi", {bus.awvalid, bus.arvalid, wr_busy, rd_busy}, 0);
    cmd(32'h100, 8'd5, 3'd2, BURST_WRAP);
    tick();
    chk("i2_done", {wr_done, rd_done}, 2'b11);
    chk("i2_resp", {wr_resp, rd_resp}, 4'b1010);
    chk("i2_noaxi", {bus.awvalid, bus.arvalid}, 0);
    cmd(32'h100, 8'd1, 3'd3, BURST_INCR);   // beat wider than bus
    rd_start = 0;
    tick();
    chk("i3_done", {wr_done, rd_done}, 2'b10);
    chk("i3_noaxi", bus.awvalid, 0);
    cmd(32'h102, 8'd3, 3'd2, BURST_WRAP);   // unaligned wrap
    wr_start = 0; rd_start = 1;
    tick();
    rd_start = 0;
    chk("i4_done", {wr_done, rd_done, rd_resp}, 4'b0110);
    chk("i4_noaxi", bus.arvalid, 0);
    tick();
    chk("i_quiet", {wr_done, rd_done, bus.awvalid, bus.arvalid}, 0);

    // ---- legal WRAP read, early rlast forces SLVERR ----
    cmd(32'h10, 8'd3, 3'd2, BURST_WRAP);
    rd_start = 1; bus.arready = 1;
    tick();
    rd_start = 0; #1;
    chk("m_arvalid", bus.arvalid, 1);
    tick();
    bus.arready = 0; bus.rvalid = 1; bus.rlast = 1; bus.rresp = RESP_OKAY;
    tick();
    bus.rvalid = 0; bus.rlast = 0; #1;
    chk("m_resp", {rd_done, rd_resp}, 3'b110);

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    // ---- write response timeout ----
    cmd(32'h300, 8'd0, 3'd2, BURST_INCR);
    wr_start = 1; bus.awready = 1; wd_valid = 1;
    tick();
    wr_start = 0;
    tick();
    tick();                                  // enters W_RESP here
    wd_valid = 0; bus.awready = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t_wait", wr_done, 0);
    end
    tick();
    chk("t_done", {wr_done, wr_resp}, 3'b111);
`endif

    // ---- async reset mid W_DATA, restart on first edge ----
    cmd(32'h500, 8'd3, 3'd2, BURST_INCR);
    wr_start = 1; bus.awready = 1; wd_valid = 1; wd_data = 32'hDEAD;
    tick();
    wr_start = 0;
    tick();
    chk("x_indata", bus.wvalid, 1);
    #2 resetn = 1'b0; #1;
    chk("x_wvalid", {bus.wvalid, bus.awvalid, bus.bready}, 0);
    chk("x_wdata",  bus.wdata, 0);
    chk("x_wstrb",  bus.wstrb, 0);
    chk("x_busy",   {wr_busy, wr_done, wr_resp}, 0);
    chk("x_awaddr", bus.awaddr, 0);
    tick();
    chk("x_nodone", wr_done, 0);
    resetn = 1'b1; wr_start = 1; bus.awready = 0;
    tick();
    wr_start = 0;
    chk("x_restart", {bus.awvalid, wr_busy, wr_done}, 3'b110);
    chk("x_readdr", bus.awaddr, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
